// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches over req/ready + rvalid, presents one instruction to decode.
// Latency: request accepted at cycle N, data at N+k -> instr_valid from N+k+1; at least 3 cycles per instruction.
// Backpressure: stall holds the presented instruction and blocks the next request; branch_taken overrides stall.
// Optional feature macro IF_MISALIGN_CHECK_EN: adds 'misaligned' output and a HALT state on misaligned redirects.
module if_fetch_stage #(
  parameter int ADDR_WIDTH = 64,
  parameter int INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
`ifdef IF_MISALIGN_CHECK_EN
  output logic                   misaligned,
`endif
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [6:0]             opcode,
  output logic [ADDR_WIDTH-1:0]  pc_out
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  // Set when the outstanding request was overtaken by a redirect; its data must be dropped.
  logic                  squash;
  logic [ADDR_WIDTH-1:0] br_tgt;

`ifdef IF_MISALIGN_CHECK_EN
  logic br_bad;
  assign br_tgt = branch_target;
  assign br_bad = branch_taken && (branch_target[1:0] != 2'b00);
`else
  // Without the check, redirects are silently word-aligned.
  assign br_tgt = branch_target & ~(ADDR_WIDTH'(3));
`endif

  // Request is gated by reset so the memory sees no request while reset is held.
  assign imem_req  = (state == S_REQ) && !reset;
  assign imem_addr = pc;
  assign opcode    = instruction[6:0];

  // Fetch FSM: PC, squash tracking and the registered decode-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      instr_valid <= 1'b0;
      instruction <= '0;
      pc_out      <= '0;
`ifdef IF_MISALIGN_CHECK_EN
      misaligned  <= 1'b0;
    end else if (br_bad && state != S_HALT) begin
      state       <= S_HALT;
      squash      <= 1'b0;
      instr_valid <= 1'b0;
      misaligned  <= 1'b1;
`endif
    end else begin
      case (state)
        S_REQ: begin
          if (branch_taken) begin
            pc <= br_tgt;
            if (imem_ready) begin
              // Request for the old PC went out this cycle; drop its data.
              state  <= S_WAIT;
              squash <= 1'b1;
            end
          end else if (imem_ready) begin
            state  <= S_WAIT;
            squash <= 1'b0;
          end
        end
        S_WAIT: begin
          if (branch_taken && imem_rvalid) begin
            pc     <= br_tgt;
            squash <= 1'b0;
            state  <= S_REQ;
          end else if (branch_taken) begin
            pc     <= br_tgt;
            squash <= 1'b1;
          end else if (imem_rvalid && squash) begin
            squash <= 1'b0;
            state  <= S_REQ;
          end else if (imem_rvalid) begin
            instruction <= imem_rdata;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + ADDR_WIDTH'(4);
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (branch_taken) begin
            instr_valid <= 1'b0;
            pc          <= br_tgt;
            state       <= S_REQ;
          end else if (!stall) begin
            instr_valid <= 1'b0;
            state       <= S_REQ;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
`timescale 1ns/1ps
// Bench for if_fetch_stage: random memory timing, stalls and redirects; the expected
// fetch stream comes from a PC-sequence model kept in a scoreboard queue.
module tb_if_fetch_stage;
  localparam int AW = 64;
  localparam int IW = 32;
  localparam logic [AW-1:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ready = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic          instr_valid;
  logic [IW-1:0] instruction;
  logic [6:0]    opcode;
  logic [AW-1:0] pc_out;

  logic          req2;
  logic [AW-1:0] addr2;
  logic          ready2 = 1'b1;
  logic          rvalid2 = 1'b0;
  logic [IW-1:0] rdata2 = '0;
  logic          stall2 = 1'b0;
  logic          br2 = 1'b0;
  logic [AW-1:0] tgt2 = '0;
  logic          valid2;
  logic [IW-1:0] instr2;
  logic [6:0]    opcode2;
  logic [AW-1:0] pcout2;
`ifdef IF_MISALIGN_CHECK_EN
  logic          misaligned;
  logic          misaligned2;
`endif

  int checks = 0;
  int passes = 0;
  logic [AW-1:0] exp_q[$];
  int pres_cnt = 0;
  logic [AW-1:0] held_pc = '0;
  logic [6:0] first_op = '0;
  int ready_pct = 100;
  int lat_min = 1;
  int lat_max = 1;
  bit pend = 1'b0;
  int pend_cnt = 0;
  logic [AW-1:0] pend_addr = '0;

  if_fetch_stage #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
`ifdef IF_MISALIGN_CHECK_EN
    .misaligned(misaligned),
`endif
    .instr_valid(instr_valid), .instruction(instruction), .opcode(opcode), .pc_out(pc_out)
  );

  if_fetch_stage #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(WRAP_PC)) dut2 (
    .clk(clk), .reset(reset),
    .imem_req(req2), .imem_addr(addr2), .imem_ready(ready2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .stall(stall2), .branch_taken(br2), .branch_target(tgt2),
`ifdef IF_MISALIGN_CHECK_EN
    .misaligned(misaligned2),
`endif
    .instr_valid(valid2), .instruction(instr2), .opcode(opcode2), .pc_out(pcout2)
  );

  always #5 clk = ~clk;

  // Memory contents as a pure function of address; address 0 holds add a0,a0,a1.
  function automatic logic [IW-1:0] memfn(input logic [AW-1:0] a);
    return 32'h00B5_0533 ^ (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  task automatic check(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic issue_branch(input logic [AW-1:0] tgt);
    branch_taken  = 1'b1;
    branch_target = tgt;
    exp_q.delete();
    exp_q.push_back(tgt & ~64'd3);
  endtask

  task automatic wait_valid(input string nm);
    int c = 0;
    while (instr_valid !== 1'b1 && c < 100) begin step(); c++; end
    check(nm, instr_valid, 1);
  endtask

  task automatic wait_req(input string nm);
    int c = 0;
    while (imem_req !== 1'b1 && c < 100) begin step(); c++; end
    check(nm, imem_req, 1);
  endtask

  task automatic wait_pres(input int n, input string nm);
    int c = 0;
    while (pres_cnt < n && c < 200) begin step(); c++; end
    check(nm, pres_cnt >= n, 1);
  endtask

  task automatic wait_mid_wait(input string nm);
    int c = 0;
    while (!(pend && pend_cnt >= 2 && !imem_req && !instr_valid) && c < 100) begin step(); c++; end
    check(nm, c < 100, 1);
  endtask

  // Instruction memory: random accept, one response 1..N cycles after each accept.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        pend = 1'b0;
        imem_rvalid = 1'b0;
        imem_ready = 1'b0;
      end else begin
        imem_rvalid = 1'b0;
        if (pend) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memfn(pend_addr);
            pend        = 1'b0;
          end
        end
        imem_ready = (int'($urandom_range(99)) < ready_pct);
        if (imem_req && imem_ready) begin
          check("one_outstanding", {63'd0, pend | imem_rvalid}, 0);
          pend      = 1'b1;
          pend_cnt  = int'($urandom_range(lat_max, lat_min));
          pend_addr = imem_addr;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each new presentation, checks holding and consumption.
  initial begin
    logic prev_v;
    logic [AW-1:0] e;
    logic [IW-1:0] d;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        if (prev_v) begin
          if (stall && !branch_taken) begin
            d = memfn(held_pc);
            check("hold_valid", instr_valid, 1);
            check("hold_pc", pc_out, held_pc);
            check("hold_instr", instruction, d);
          end else begin
            check("consume_drop", instr_valid, 0);
          end
        end else if (instr_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL sb_empty: unexpected instruction at pc 0x%0h, expected none", pc_out);
          end else begin
            e = exp_q.pop_front();
            d = memfn(e);
            check("pres_pc", pc_out, e);
            check("pres_instr", instruction, d);
            check("pres_opcode", opcode, d[6:0]);
            exp_q.push_back(e + 64'd4);
            held_pc = e;
            if (pres_cnt == 0) first_op = opcode;
            pres_cnt++;
          end
        end
        if (instr_valid) check("held_no_req", imem_req, 0);
        prev_v = instr_valid;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] tgt;
    int n;
    bit saw_req;
    exp_q.push_back(64'd0);

    // Reset values while reset is held
    #12;
    check("rst_valid", instr_valid, 0);
    check("rst_req", imem_req, 0);
    check("rst_instr", instruction, 0);
    check("rst_pc_out", pc_out, 0);
    check("rst_opcode", opcode, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_addr2", addr2, WRAP_PC);
`ifdef IF_MISALIGN_CHECK_EN
    check("rst_misaligned", misaligned, 0);
`endif
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;

    // First cycle out of reset; second instance exercises the PC wrap from RESET_PC
    step();
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 0);
    check("wrap_req2", req2, 1);
    check("wrap_addr2", addr2, WRAP_PC);
    step();
    rvalid2 = 1'b1;
    rdata2  = 32'h00B5_0533;
    step();
    rvalid2 = 1'b0;
    check("wrap_valid2", valid2, 1);
    check("wrap_pcout2", pcout2, WRAP_PC);
    check("wrap_instr2", instr2, 32'h00B5_0533);
    check("wrap_opcode2", opcode2, 7'h33);
    step();
    check("wrap_drop2", valid2, 0);
    check("wrap_next_req2", req2, 1);
    check("wrap_next_addr2", addr2, 0);

    // Back-to-back fetch with an always-ready, 1-cycle memory
    wait_pres(3, "seq_progress");
    check("first_opcode", first_op, 7'h33);

    // Stall held in HOLD for 5 cycles
    stall = 1'b1;
    wait_valid("stall_valid");
    repeat (5) begin
      step();
      check("stall_no_req", imem_req, 0);
    end
    check("stall_still_valid", instr_valid, 1);
    stall = 1'b0;
    wait_req("stall_next_req");
    check("stall_next_addr", imem_addr, held_pc + 64'd4);

    // Redirect while waiting on memory: data for the old PC is discarded
    lat_min = 3; lat_max = 3;
    wait_mid_wait("br_wait_reach");
    issue_branch(64'h100);
    step();
    branch_taken = 1'b0;
    n = pres_cnt;
    wait_req("br_wait_req");
    check("br_wait_addr", imem_addr, 64'h100);
    wait_pres(n + 1, "br_wait_pres");
    check("br_wait_pc", held_pc, 64'h100);

    // Redirect while holding under stall
    lat_min = 1; lat_max = 1;
    stall = 1'b1;
    wait_valid("br_hold_valid");
    step();
    step();
    issue_branch(64'h200);
    step();
    branch_taken = 1'b0;
    stall = 1'b0;
    check("br_hold_drop", instr_valid, 0);
    check("br_hold_req", imem_req, 1);
    check("br_hold_addr", imem_addr, 64'h200);

    // PC increment wraps at the top of the address space
    issue_branch(WRAP_PC);
    step();
    branch_taken = 1'b0;
    n = pres_cnt;
    wait_pres(n + 1, "wrap_pres");
    check("wrap_pc", held_pc, WRAP_PC);
    wait_req("wrap_req");
    check("wrap_next_addr", imem_addr, 64'd0);

    // Randomized memory timing, stalls and redirects
    ready_pct = 70; lat_min = 1; lat_max = 4;
    n = pres_cnt;
    for (int i = 0; i < 3000; i++) begin
      step();
      stall = (int'($urandom_range(99)) < 35);
      if (!branch_taken && int'($urandom_range(99)) < 6) begin
        tgt = {$urandom, $urandom};
`ifdef IF_MISALIGN_CHECK_EN
        tgt[1:0] = 2'b00;
`endif
        issue_branch(tgt);
      end else begin
        branch_taken = 1'b0;
      end
    end
    step();
    stall = 1'b0;
    branch_taken = 1'b0;
    check("random_progress", (pres_cnt - n) >= 100, 1);

    // Asynchronous reset in the middle of a memory wait
    ready_pct = 100; lat_min = 3; lat_max = 3;
    wait_mid_wait("rst_mid_reach");
    #1 reset = 1'b1;
    #1;
    check("rst_mid_valid", instr_valid, 0);
    check("rst_mid_req", imem_req, 0);
    exp_q.delete();
    exp_q.push_back(64'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    step();
    check("rst_mid_first_req", imem_req, 1);
    check("rst_mid_first_addr", imem_addr, 0);
    n = pres_cnt;
    wait_pres(n + 1, "rst_mid_refetch");
    check("rst_mid_refetch_pc", held_pc, 0);

`ifdef IF_MISALIGN_CHECK_EN
    // Misaligned redirect halts fetch for good
    lat_min = 1; lat_max = 1;
    issue_branch(64'h102);
    exp_q.delete();
    step();
    branch_taken = 1'b0;
    check("mis_flag", misaligned, 1);
    check("mis_valid", instr_valid, 0);
    saw_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      branch_taken = (i == 5);
      branch_target = 64'h300;
      if (imem_req) saw_req = 1'b1;
    end
    branch_taken = 1'b0;
    check("mis_no_req", saw_req, 0);
    check("mis_sticky", misaligned, 1);
    check("mis_other_inst", misaligned2, 0);
`else
    saw_req = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction fetch stage directly upstream of the main decoder; owns the PC and talks to instruction memory over a req/ready + rvalid handshake.
- Presents one instruction, its PC and its opcode field (instruction[6:0]) to decode, holding them while decode stalls.
- Accepts taken-branch redirects from the execute stage; branch has priority over stall.

Parameters:
ADDR_WIDTH, 64, width of PC and instruction-memory address
INSTR_WIDTH, 32, instruction width (fixed RV32 encoding, must be 32)
RESET_PC, 0, PC loaded on reset

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
imem_req  output  1  fetch request valid
imem_addr  output  ADDR_WIDTH  fetch address (current PC)
imem_ready  input  1  memory accepts request this cycle when imem_req=1
imem_rvalid  input  1  read data valid, exactly one per accepted request, 1+ cycles after accept
imem_rdata  input  INSTR_WIDTH  read data
stall  input  1  decode cannot consume the presented instruction
branch_taken  input  1  single-cycle redirect pulse
branch_target  input  ADDR_WIDTH  redirect address, valid with branch_taken
instr_valid  output  1  instruction/pc_out/opcode valid
instruction  output  INSTR_WIDTH  registered instruction
opcode  output  7  instruction[6:0], combinational from instruction register
pc_out  output  ADDR_WIDTH  PC of presented instruction

Behaviour:
- Reset (async): state=REQ, pc=RESET_PC, squash=0, instr_valid=0, instruction=0, pc_out=0; imem_req=1 in the first cycle after reset deasserts.
- imem_addr=pc at all times; imem_req=1 only in REQ.
- REQ: if branch_taken: pc<=branch_target; if imem_ready also high, go WAIT with squash<=1, else stay REQ. Else if imem_ready: go WAIT.
- WAIT: imem_req=0.
  - branch_taken & imem_rvalid: discard data, pc<=target, squash<=0, go REQ.
  - branch_taken only: pc<=target, squash<=1, stay WAIT.
  - imem_rvalid & squash: discard, squash<=0, go REQ.
  - imem_rvalid & !squash: instruction<=imem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+4, go HOLD.
- HOLD: instr_valid=1, outputs stable.
  - branch_taken: instr_valid<=0, pc<=target, go REQ (stall ignored).
  - !stall: consumed this cycle; instr_valid<=0, go REQ.
  - stall: stay HOLD.
- Latency: accept at cycle N, rvalid at N+k -> instr_valid from N+k+1; minimum 3 cycles per instruction (REQ, WAIT, HOLD).
- pc+4 wraps modulo 2^ADDR_WIDTH (all-ones-minus-3 -> 0).
- At most one outstanding request; a request is never issued while an instruction is held.
- Reset mid-transaction: any later imem_rvalid for the abandoned request must not arrive (memory is reset with the same reset); none is tracked.
- No X on outputs after reset; opcode always equals instruction[6:0].

Optional Feature:
- Macro IF_MISALIGN_CHECK_EN.
- Defined: adds output misaligned (1 bit, reset 0). A branch_taken with branch_target[1:0]!=0 sets misaligned (sticky until reset), clears instr_valid and sends FSM to HALT: imem_req=0 forever, further branches ignored.
- Not defined: no port; branch_target[1:0] forced to 2'b00 when loaded into pc.

Test Plan:
- Reset, memory ready=1, rvalid 1 cycle after accept, stall=0 -> addresses 0x0,0x4,0x8 requested; instr_valid pulses with pc_out 0x0,0x4,0x8 and matching data; opcode=0x33 for data 0x00B50533.
- stall held 5 cycles in HOLD -> instruction/pc_out unchanged, imem_req=0 throughout, next request 0x4 only after stall drops.
- branch_taken target 0x100 in WAIT before rvalid -> returned data discarded, next request to 0x100, no instr_valid for old PC.
- branch_taken target 0x200 in HOLD with stall=1 -> instr_valid drops next cycle, next request 0x200.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one fetch -> next request address 0x0.
- Async reset asserted mid-WAIT (no clock edge) -> instr_valid=0, imem_req=0 immediately; after release first request at RESET_PC. With IF_MISALIGN_CHECK_EN: target 0x102 -> misaligned=1, no further imem_req.
